blade_ignition: RTL and testbench

Downstream stage of the blade-length setter: it consumes the registered blade length (meters part, centimetre part) and the hilt length, then animates blade ignition and retraction. On ignite it grows the emitted blade length in fixed centimetre steps up to the latched target. On retract it shrinks the blade back to zero. It also reports the total saber span for the configured blade layout. Its outputs drive the display/emitter logic.

---
 rtl/blade_ignition.sv | 146 ++++++++++++++
 tb/tb_blade_ignition.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/blade_ignition.sv
// Blade ignition/retraction animator: steps the emitted blade length toward a latched
// target (or back to zero) and reports the total saber span for the latched layout.
module blade_ignition #(
  parameter int unsigned STEP_CM = 5,
  parameter int unsigned W       = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ignite,
  input  logic         retract,
  input  logic [W-1:0] lengthL,
  input  logic [W-1:0] lengthR,
  input  logic [W-1:0] lengthH,
  input  logic [1:0]   bladeConfig,
  output logic [W-1:0] bladeCm,
  output logic [W-1:0] totalCm,
  output logic [1:0]   state,
  output logic         lit,
  output logic         busy,
  output logic         fault
);

  typedef enum logic [1:0] {
    S_OFF = 2'd0,
    S_EXT = 2'd1,
    S_ON  = 2'd2,
    S_RET = 2'd3
  } state_t;

  localparam logic [W-1:0] MAX_CM = W'(100);
  localparam logic [W-1:0] STEP_W = W'(STEP_CM);

  state_t       state_q, state_d;
  logic [W-1:0] blade_q, blade_d;
  logic [W-1:0] total_q, total_d;
  logic [W-1:0] target_q, target_d;
  logic [1:0]   cfg_q, cfg_d;
  logic [W-1:0] hilt_q, hilt_d;
  logic         lit_q, lit_d;
  logic         busy_q, busy_d;
  logic         fault_q, fault_d;

  logic [W-1:0] tgt_calc;
  logic         reject;
  logic [W:0]   up_sum;
  logic [W-1:0] up_val, dn_val;
  logic [W+1:0] span_raw;

  function automatic logic [W-1:0] sat_w(input logic [W+1:0] v);
    return (v[W+1:W] != 2'b00) ? '1 : v[W-1:0];
  endfunction

  always_comb begin
    tgt_calc = (lengthL != '0) ? MAX_CM : ((lengthR > MAX_CM) ? MAX_CM : lengthR);
    reject   = (bladeConfig == 2'd0) || lengthL[W-1] || lengthR[W-1] || (tgt_calc == '0);
    up_sum   = {1'b0, blade_q} + {1'b0, STEP_W};
    up_val   = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[W-1:0];
    dn_val   = (blade_q > STEP_W) ? (blade_q - STEP_W) : '0;
  end

  always_comb begin
    state_d  = state_q;
    blade_d  = blade_q;
    target_d = target_q;
    cfg_d    = cfg_q;
    hilt_d   = hilt_q;
    fault_d  = 1'b0;
    case (state_q)
      S_OFF: begin
        // Simultaneous ignite+retract in OFF is a silent no-op.
        if (ignite && !retract) begin
          if (reject) begin
            fault_d = 1'b1;
          end else begin
            state_d  = S_EXT;
            target_d = tgt_calc;
            cfg_d    = bladeConfig;
            hilt_d   = (bladeConfig == 2'd3) ? lengthH : '0;
          end
        end
      end
      S_EXT: begin
        if (retract) begin
          state_d = S_RET;
        end else begin
          blade_d = up_val;
          if (up_val == target_q) state_d = S_ON;
        end
      end
      S_ON: begin
        if (retract) state_d = S_RET;
      end
      default: begin
        if (ignite && !retract) begin
          state_d = S_EXT;
        end else begin
          blade_d = dn_val;
          if (dn_val == '0) state_d = S_OFF;
        end
      end
    endcase

    span_raw = '0;
    case (cfg_d)
      2'd1:    span_raw = {2'b00, blade_d};
      2'd2:    span_raw = {1'b0, blade_d, 1'b0};
      2'd3:    span_raw = {1'b0, blade_d, 1'b0} + {2'b00, hilt_d};
      default: span_raw = '0;
    endcase
    total_d = sat_w(span_raw);
    lit_d   = (state_d == S_ON);
    busy_d  = (state_d == S_EXT) || (state_d == S_RET);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_OFF;
      blade_q  <= '0;
      total_q  <= '0;
      target_q <= '0;
      cfg_q    <= 2'd0;
      hilt_q   <= '0;
      lit_q    <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      blade_q  <= blade_d;
      total_q  <= total_d;
      target_q <= target_d;
      cfg_q    <= cfg_d;
      hilt_q   <= hilt_d;
      lit_q    <= lit_d;
      busy_q   <= busy_d;
      fault_q  <= fault_d;
    end
  end

  assign bladeCm = blade_q;
  assign totalCm = total_q;
  assign state   = state_q;
  assign lit     = lit_q;
  assign busy    = busy_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_blade_ignition.sv
// Directed bench for blade_ignition: ignition, retraction, rejections, interrupts and reset.
module tb_blade_ignition;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ignite = 1'b0;
  logic         retract = 1'b0;
  logic [W-1:0] lengthL = '0;
  logic [W-1:0] lengthR = '0;
  logic [W-1:0] lengthH = '0;
  logic [1:0]   bladeConfig = 2'd0;
  logic [W-1:0] bladeCm, totalCm;
  logic [1:0]   state_o;
  logic         lit, busy, fault;

  int total = 0;
  int bad   = 0;

  blade_ignition #(.STEP_CM(5), .W(W)) dut (
    .clk(clk), .rst(rst), .ignite(ignite), .retract(retract),
    .lengthL(lengthL), .lengthR(lengthR), .lengthH(lengthH),
    .bladeConfig(bladeConfig), .bladeCm(bladeCm), .totalCm(totalCm),
    .state(state_o), .lit(lit), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    // reset state
    tick();
    rst = 1'b0;
    chk("rst_blade", bladeCm, 0);
    chk("rst_total", totalCm, 0);
    chk("rst_state", state_o, 0);
    chk("rst_lit", lit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);

    // single blade, target 50
    lengthL = 0; lengthR = 50; bladeConfig = 2'd1; ignite = 1;
    tick();
    ignite = 0;
    chk("t1_acc_state", state_o, 1);
    chk("t1_acc_busy", busy, 1);
    chk("t1_acc_blade", bladeCm, 0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("t1_ext_blade", bladeCm, 5 * i);
      chk("t1_ext_total", totalCm, 5 * i);
    end
    chk("t1_on_state", state_o, 2);
    chk("t1_on_lit", lit, 1);
    chk("t1_on_busy", busy, 0);
    retract = 1;
    tick();
    retract = 0;
    chk("t1_ret_state", state_o, 3);
    chk("t1_ret_blade", bladeCm, 50);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("t1_ret_step", bladeCm, 50 - 5 * i);
    end
    chk("t1_off_state", state_o, 0);
    chk("t1_off_busy", busy, 0);

    // double blade with hilt
    lengthL = 1; lengthR = 0; bladeConfig = 2'd3; lengthH = 10; ignite = 1;
    tick();
    ignite = 0;
    chk("t2_acc_state", state_o, 1);
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("t2_ext_total", totalCm, 10 * i + 10);
    end
    chk("t2_on_blade", bladeCm, 100);
    chk("t2_on_total", totalCm, 210);
    chk("t2_on_state", state_o, 2);
    lengthH = 50; lengthR = 30; lengthL = 0; ignite = 1;
    tick();
    ignite = 0;
    chk("t2_hold_total", totalCm, 210);
    chk("t2_hold_state", state_o, 2);
    retract = 1;
    tick();
    retract = 0;
    for (int i = 1; i <= 20; i++) tick();
    chk("t2_off_state", state_o, 0);
    chk("t2_off_blade", bladeCm, 0);

    // rejections
    lengthL = 0; lengthR = 50; bladeConfig = 2'd0; ignite = 1;
    tick();
    ignite = 0;
    chk("rej_cfg_fault", fault, 1);
    chk("rej_cfg_state", state_o, 0);
    tick();
    chk("rej_cfg_pulse", fault, 0);
    bladeConfig = 2'd1; lengthL = 16'hFFFF; ignite = 1;
    tick();
    chk("rej_neg_fault", fault, 1);
    chk("rej_neg_state", state_o, 0);
    tick();
    ignite = 0;
    chk("rej_held_fault", fault, 1);
    tick();
    chk("rej_neg_pulse", fault, 0);
    lengthL = 0; lengthR = 0; ignite = 1;
    tick();
    ignite = 0;
    chk("rej_zero_fault", fault, 1);
    chk("rej_zero_state", state_o, 0);
    tick();
    chk("rej_zero_pulse", fault, 0);
    bladeConfig = 2'd0; ignite = 1; retract = 1;
    tick();
    ignite = 0; retract = 0;
    chk("both_off_fault", fault, 0);
    chk("both_off_state", state_o, 0);

    // non-multiple target 23, double blade
    lengthL = 0; lengthR = 23; bladeConfig = 2'd2; ignite = 1;
    tick();
    ignite = 0;
    chk("t4_acc_fault", fault, 0);
    begin
      int up[5] = '{5, 10, 15, 20, 23};
      int dn[5] = '{18, 13, 8, 3, 0};
      for (int i = 0; i < 5; i++) begin
        tick();
        chk("t4_ext_blade", bladeCm, up[i]);
        chk("t4_ext_total", totalCm, 2 * up[i]);
      end
      chk("t4_on_state", state_o, 2);
      retract = 1;
      tick();
      retract = 0;
      chk("t4_ret_blade", bladeCm, 23);
      for (int i = 0; i < 5; i++) begin
        tick();
        chk("t4_ret_blade", bladeCm, dn[i]);
      end
    end
    chk("t4_off_state", state_o, 0);

    // interrupts, target clamped to 100
    lengthL = 0; lengthR = 200; bladeConfig = 2'd1; ignite = 1;
    tick();
    ignite = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("t5_at30", bladeCm, 30);
    retract = 1;
    tick();
    retract = 0;
    chk("t5_ret_state", state_o, 3);
    chk("t5_ret_blade", bladeCm, 30);
    tick();
    chk("t5_ret_25", bladeCm, 25);
    tick();
    tick();
    chk("t5_ret_15", bladeCm, 15);
    ignite = 1;
    tick();
    ignite = 0;
    chk("t5_re_state", state_o, 1);
    chk("t5_re_blade", bladeCm, 15);
    tick();
    tick();
    chk("t5_re_25", bladeCm, 25);
    ignite = 1; retract = 1;
    tick();
    chk("t5_both_state", state_o, 3);
    chk("t5_both_blade", bladeCm, 25);
    tick();
    ignite = 0; retract = 0;
    chk("t5_both_step", bladeCm, 20);
    chk("t5_both_st2", state_o, 3);
    for (int i = 0; i < 4; i++) tick();
    chk("t5_off_state", state_o, 0);
    chk("t5_off_blade", bladeCm, 0);

    // reset mid-extension, then fresh target
    lengthR = 100; ignite = 1;
    tick();
    ignite = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("t6_at40", bladeCm, 40);
    rst = 1;
    tick();
    rst = 0;
    chk("t6_rst_blade", bladeCm, 0);
    chk("t6_rst_total", totalCm, 0);
    chk("t6_rst_state", state_o, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_lit", lit, 0);
    lengthR = 10; ignite = 1;
    tick();
    ignite = 0;
    tick();
    tick();
    chk("t6_new_blade", bladeCm, 10);
    chk("t6_new_state", state_o, 2);
    chk("t6_new_lit", lit, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
